// File: rtl/bomb_engine.sv
`default_nettype none
// ============================================================================
// Module   : bomb_engine
// Purpose  : Per-cell fuse counters, N-player bomb plants, cross-shaped blast
//            map, once-per-tick damage and a latched match result.
//            Optional feature macro: BOMB_CHAIN_EN (blasts shorten other fuses).
// Revision : 1.0 - initial release
// ============================================================================
module bomb_engine #(
    parameter int GRID_W     = 10,
    parameter int GRID_H     = 10,
    parameter int CW         = 4,
    parameter int N_PLAYERS  = 2,
    parameter int FUSE_TICKS = 3,
    parameter int BLAST_R    = 2,
    parameter int MAX_HEALTH = 3,
    parameter int HW         = 2
) (
    input  logic                      bombClk,
    input  logic                      rst,
    input  logic [N_PLAYERS-1:0]      plant_v,
    input  logic [N_PLAYERS*CW-1:0]   plant_x,
    input  logic [N_PLAYERS*CW-1:0]   plant_y,
    input  logic [N_PLAYERS*CW-1:0]   player_x,
    input  logic [N_PLAYERS*CW-1:0]   player_y,
    output logic [N_PLAYERS-1:0]      plant_ack,
    output logic [GRID_W*GRID_H-1:0]  bomb_map,
    output logic [GRID_W*GRID_H-1:0]  blast_map,
    output logic [N_PLAYERS*HW-1:0]   health,
    output logic [1:0]                game_state,
    output logic [2:0]                winner
);

    localparam int NC = GRID_W * GRID_H;
    localparam int FW = (FUSE_TICKS < 2) ? 1 : $clog2(FUSE_TICKS + 1);
    localparam logic [FW-1:0] C_FUSE_LOAD  = FW'(FUSE_TICKS);
    localparam logic [FW-1:0] C_FUSE_ONE   = FW'(1);
    localparam logic [HW-1:0] C_HEALTH_RST = HW'(MAX_HEALTH);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WIN  = 2'd1,
        ST_DRAW = 2'd2
    } state_e;

    logic [FW-1:0]           fuse_q [NC];
    logic [FW-1:0]           fuse_d [NC];
    logic [NC-1:0]           blast_q, blast_d;
    logic [NC-1:0]           detonate, plant_mask;
    logic [N_PLAYERS-1:0]    ack_q, ack_d, cand;
    logic [N_PLAYERS*HW-1:0] health_q, health_d;
    state_e                  state_q, state_d;
    logic [2:0]              winner_q, winner_d;
    int                      pcell [N_PLAYERS];

    // Plant qualification; a lower-indexed player claiming the same cell wins.
    always_comb begin
        int px, py;
        cand       = '0;
        ack_d      = '0;
        plant_mask = '0;
        px         = 0;
        py         = 0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            pcell[p] = 0;
        end
        for (int p = 0; p < N_PLAYERS; p++) begin
            px = int'(plant_x[CW*p +: CW]);
            py = int'(plant_y[CW*p +: CW]);
            if (state_q == ST_RUN && plant_v[p] &&
                px >= 1 && px <= GRID_W - 2 && py >= 1 && py <= GRID_H - 2) begin
                pcell[p] = py * GRID_W + px;
                if (fuse_q[pcell[p]] == '0 && !blast_q[pcell[p]]) begin
                    cand[p] = 1'b1;
                end
            end
        end
        for (int p = 0; p < N_PLAYERS; p++) begin
            ack_d[p] = cand[p];
            for (int q = 0; q < p; q++) begin
                if (cand[q] && pcell[q] == pcell[p]) begin
                    ack_d[p] = 1'b0;
                end
            end
            if (ack_d[p]) begin
                plant_mask[pcell[p]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NC; c++) begin
            detonate[c] = (fuse_q[c] == C_FUSE_ONE);
            fuse_d[c]   = fuse_q[c];
            if (fuse_q[c] != '0) begin
                fuse_d[c] = fuse_q[c] - C_FUSE_ONE;
            end
`ifdef BOMB_CHAIN_EN
            if (blast_q[c] && fuse_q[c] > C_FUSE_ONE) begin
                fuse_d[c] = C_FUSE_ONE;
            end
`endif
            if (plant_mask[c]) begin
                fuse_d[c] = C_FUSE_LOAD;
            end
        end
    end

    // Cross of every detonating cell, clipped at the arena border.
    always_comb begin
        blast_d = '0;
        for (int y = 0; y < GRID_H; y++) begin
            for (int x = 0; x < GRID_W; x++) begin
                if (detonate[y*GRID_W + x]) begin
                    for (int k = 0; k <= BLAST_R; k++) begin
                        if (x + k < GRID_W) blast_d[y*GRID_W + x + k]   = 1'b1;
                        if (x - k >= 0)     blast_d[y*GRID_W + x - k]   = 1'b1;
                        if (y + k < GRID_H) blast_d[(y+k)*GRID_W + x]   = 1'b1;
                        if (y - k >= 0)     blast_d[(y-k)*GRID_W + x]   = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        int hx, hy;
        logic [HW-1:0] h;
        health_d = health_q;
        hx       = 0;
        hy       = 0;
        h        = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            hx = int'(player_x[CW*p +: CW]);
            hy = int'(player_y[CW*p +: CW]);
            h  = health_q[HW*p +: HW];
            if (state_q == ST_RUN && hx < GRID_W && hy < GRID_H && h != '0) begin
                if (blast_q[hy*GRID_W + hx]) begin
                    health_d[HW*p +: HW] = h - HW'(1);
                end
            end
        end
    end

    always_comb begin
        int         alive_cnt;
        logic [2:0] alive_idx;
        state_d   = state_q;
        winner_d  = winner_q;
        alive_cnt = 0;
        alive_idx = 3'd0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (health_q[HW*p +: HW] != '0) begin
                alive_cnt = alive_cnt + 1;
                alive_idx = 3'(p);
            end
        end
        case (state_q)
            ST_RUN: begin
                if (alive_cnt == 1) begin
                    state_d  = ST_WIN;
                    winner_d = alive_idx;
                end else if (alive_cnt == 0) begin
                    state_d = ST_DRAW;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge bombClk) begin
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                fuse_q[c] <= '0;
            end
            blast_q  <= '0;
            ack_q    <= '0;
            health_q <= {N_PLAYERS{C_HEALTH_RST}};
        end else begin
            for (int c = 0; c < NC; c++) begin
                fuse_q[c] <= fuse_d[c];
            end
            blast_q  <= blast_d;
            ack_q    <= ack_d;
            health_q <= health_d;
        end
    end

    always_ff @(posedge bombClk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            winner_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
        end
    end

    for (genvar c = 0; c < NC; c++) begin : g_bomb_map
        assign bomb_map[c] = |fuse_q[c];
    end

    assign blast_map  = blast_q;
    assign plant_ack  = ack_q;
    assign health     = health_q;
    assign game_state = state_q;
    assign winner     = winner_q;

endmodule
`default_nettype wire
